class_vote_aggregator: RTL and testbench

- Parametrised temporal voting stage that sits after the FC classifier in the camera CNN pipeline, in the camera pixel-clock domain.
- Each valid score vector casts one vote for its argmax class after a selectable per-class bias is added.
- Over a fixed window of VOTE_PERIOD cycles it tallies per-class votes, then publishes the winning class code for LED and OSD.
- Generalises the fixed 3-class voter: N classes, configurable widths, a minimum-vote confidence gate, saturating counters, a stepped bias selector and a decision strobe.

---
 rtl/class_vote_aggregator_if.sv | 27 ++
 rtl/class_vote_aggregator.sv | 132 +++++++++++++
 tb/tb_class_vote_aggregator.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/class_vote_aggregator_if.sv
// Handshake/bus bundle between the FC classifier output stage and the vote aggregator.
interface class_vote_aggregator_if #(
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned SCORE_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
);
  localparam int unsigned CODE_W = $clog2(NUM_CLASSES + 1);

  logic                               en;
  logic                               valid_in;
  logic [NUM_CLASSES*SCORE_WIDTH-1:0] scores_in;
  logic                               bias_next;
  logic [CODE_W-1:0]                  bias_sel;
  logic                               decision_valid;
  logic [CODE_W-1:0]                  class_code;
  logic [CNT_WIDTH-1:0]               win_votes;

  modport master (
    output en, valid_in, scores_in, bias_next,
    input  bias_sel, decision_valid, class_code, win_votes
  );

  modport slave (
    input  en, valid_in, scores_in, bias_next,
    output bias_sel, decision_valid, class_code, win_votes
  );
endinterface

// File: rtl/class_vote_aggregator.sv
// Temporal argmax voter: tallies biased per-class votes over a fixed window and publishes the winner.
// Optional VOTE_HYST_EN: a class code must win two consecutive windows before class_code changes.
module class_vote_aggregator #(
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned SCORE_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned TIMER_WIDTH = 32,
  parameter int unsigned VOTE_PERIOD = 25000000,
  parameter int unsigned MIN_VOTES   = 1,
  parameter int          BIAS_STEP   = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  class_vote_aggregator_if.slave  bus
);
  localparam int unsigned CODE_W = $clog2(NUM_CLASSES + 1);
  localparam int unsigned SX_W   = SCORE_WIDTH + 1;
  localparam int unsigned TOT_W  = CNT_WIDTH + 3;

  localparam logic signed [SX_W-1:0]  BIAS_X  = SX_W'(BIAS_STEP);
  localparam logic [TIMER_WIDTH-1:0]  LAST_T  = TIMER_WIDTH'(VOTE_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX = '1;
  localparam logic [TOT_W-1:0]        TOT_MAX = '1;
  localparam logic [TOT_W-1:0]        MIN_T   = TOT_W'(MIN_VOTES);

  logic [TIMER_WIDTH-1:0]   timer_q;
  logic [CNT_WIDTH-1:0]     cnt_q [NUM_CLASSES];
  logic [CNT_WIDTH-1:0]     cnt_d [NUM_CLASSES];
  logic [TOT_W-1:0]         total_q, total_d;
  logic [CODE_W-1:0]        bias_sel_q;
  logic                     decision_valid_q;
  logic [CODE_W-1:0]        class_code_q;
  logic [CNT_WIDTH-1:0]     win_votes_q;

  logic signed [SX_W-1:0]   biased_c [NUM_CLASSES];
  logic signed [SX_W-1:0]   best_c;
  logic [CODE_W-1:0]        vote_idx_c, win_idx_c, code_c;
  logic [CNT_WIDTH-1:0]     win_cnt_c;
  logic                     vote_c, close_c;

`ifdef VOTE_HYST_EN
  logic [CODE_W-1:0]        cand_q;
`endif

  assign vote_c  = bus.en && bus.valid_in;
  assign close_c = bus.en && (timer_q == LAST_T);

  // Sign-extend, apply the selected bias, strict-greater argmax so ties keep the lowest index
  always_comb begin
    best_c     = '0;
    vote_idx_c = '0;
    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
      biased_c[k] = $signed({bus.scores_in[k*SCORE_WIDTH + SCORE_WIDTH - 1],
                             bus.scores_in[k*SCORE_WIDTH +: SCORE_WIDTH]});
      if (bias_sel_q == CODE_W'(k + 1)) begin
        biased_c[k] = biased_c[k] + BIAS_X;
      end
      if (k == 0 || biased_c[k] > best_c) begin
        best_c     = biased_c[k];
        vote_idx_c = CODE_W'(k);
      end
    end
  end

  // Saturating per-class counts; the total only moves when a count actually moves
  always_comb begin
    total_d = total_q;
    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
      cnt_d[k] = cnt_q[k];
      if (vote_c && vote_idx_c == CODE_W'(k) && cnt_q[k] != CNT_MAX) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        if (total_q != TOT_MAX) begin
          total_d = total_q + TOT_W'(1);
        end
      end
    end
  end

  // Winner over the counts including this cycle's vote
  always_comb begin
    win_idx_c = '0;
    win_cnt_c = cnt_d[0];
    for (int k = 1; k < int'(NUM_CLASSES); k++) begin
      if (cnt_d[k] > win_cnt_c) begin
        win_cnt_c = cnt_d[k];
        win_idx_c = CODE_W'(k);
      end
    end
    code_c = (total_d < MIN_T) ? '0 : win_idx_c + CODE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q          <= '0;
      total_q          <= '0;
      bias_sel_q       <= '0;
      decision_valid_q <= 1'b0;
      class_code_q     <= '0;
      win_votes_q      <= '0;
      for (int k = 0; k < int'(NUM_CLASSES); k++) cnt_q[k] <= '0;
`ifdef VOTE_HYST_EN
      cand_q           <= '0;
`endif
    end else begin
      if (bus.bias_next) begin
        bias_sel_q <= (bias_sel_q == CODE_W'(NUM_CLASSES)) ? '0 : bias_sel_q + CODE_W'(1);
      end
      decision_valid_q <= close_c;
      if (close_c) begin
        timer_q     <= '0;
        total_q     <= '0;
        for (int k = 0; k < int'(NUM_CLASSES); k++) cnt_q[k] <= '0;
        win_votes_q <= (total_d < MIN_T) ? '0 : win_cnt_c;
`ifdef VOTE_HYST_EN
        if (code_c == cand_q) class_code_q <= code_c;
        cand_q <= code_c;
`else
        class_code_q <= code_c;
`endif
      end else if (bus.en) begin
        timer_q <= timer_q + TIMER_WIDTH'(1);
        total_q <= total_d;
        for (int k = 0; k < int'(NUM_CLASSES); k++) cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.bias_sel       = bias_sel_q;
  assign bus.decision_valid = decision_valid_q;
  assign bus.class_code     = class_code_q;
  assign bus.win_votes      = win_votes_q;
endmodule

// File: tb/tb_class_vote_aggregator.sv
// Bench for class_vote_aggregator: window table plus hand sequences, decisions checked from a scoreboard queue.
module tb_class_vote_aggregator;
  localparam int unsigned NC     = 3;
  localparam int unsigned SW     = 32;
  localparam int unsigned CW     = 4;
  localparam int unsigned VP     = 16;
  localparam int unsigned CODE_W = $clog2(NC + 1);

  typedef struct {
    string name;
    int n_a; int a0; int a1; int a2;
    int n_b; int b0; int b1; int b2;
    int pulses; int code; int votes;
  } win_t;

  typedef struct { int code; int votes; int at; } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   bsel_exp = 0;
  int   shown = 0;
`ifdef VOTE_HYST_EN
  int   cand = 0;
`endif
  exp_t exp_q[$];
  exp_t mon_e;
  win_t tbl[7];
  win_t w4[3];

  class_vote_aggregator_if #(.NUM_CLASSES(NC), .SCORE_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  class_vote_aggregator #(
    .NUM_CLASSES(NC), .SCORE_WIDTH(SW), .CNT_WIDTH(CW), .TIMER_WIDTH(8),
    .VOTE_PERIOD(VP), .MIN_VOTES(2), .BIAS_STEP(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Expected decision, folded through the two-window confirmation when that option is built
  task automatic push_exp(input int raw, input int votes, input int at);
    exp_t e;
`ifdef VOTE_HYST_EN
    if (raw == cand) shown = raw;
    cand = raw;
`else
    shown = raw;
`endif
    e.code = shown; e.votes = votes; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic set_vec(input int s0, input int s1, input int s2);
    bus.scores_in = {SW'(s2), SW'(s1), SW'(s0)};
  endtask

  task automatic idle();
    bus.en = 1'b1; bus.valid_in = 1'b0; bus.bias_next = 1'b0; set_vec(0, 0, 0);
  endtask

  // Entry and exit at a negedge; leaves the DUT about to consume timer=0
  task automatic do_reset();
    rst = 1'b1; idle();
    @(negedge clk);
    rst = 1'b0;
    chk("reset class_code", int'(bus.class_code), 0);
    chk("reset win_votes", int'(bus.win_votes), 0);
    chk("reset decision_valid", int'(bus.decision_valid), 0);
    chk("reset bias_sel", int'(bus.bias_sel), 0);
    bsel_exp = 0; shown = 0;
`ifdef VOTE_HYST_EN
    cand = 0;
`endif
  endtask

  task automatic apply_window(input win_t w);
    int idx;
    for (int c = 0; c < int'(VP); c++) begin
      if (c == 0) push_exp(w.code, w.votes, cyc + int'(VP));
      if (c > 0 && c <= w.pulses) chk({w.name, " bias_sel"}, int'(bus.bias_sel), bsel_exp);
      bus.bias_next = (c < w.pulses);
      if (c < w.pulses) bsel_exp = (bsel_exp == int'(NC)) ? 0 : bsel_exp + 1;
      idx = c - w.pulses;
      if (idx >= 0 && idx < w.n_a) begin
        bus.valid_in = 1'b1; set_vec(w.a0, w.a1, w.a2);
      end else if (idx >= w.n_a && idx < w.n_a + w.n_b) begin
        bus.valid_in = 1'b1; set_vec(w.b0, w.b1, w.b2);
      end else begin
        bus.valid_in = 1'b0; set_vec(0, 0, 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int budget = 4;
    #1;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (exp_q.size() != 0) begin
      chk("decision timeout (outstanding)", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.decision_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious decision_valid", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("class_code", int'(bus.class_code), mon_e.code);
        chk("win_votes", int'(bus.win_votes), mon_e.votes);
        chk("close timing", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; idle();
    tbl[0] = '{"class1_majority", 5, 0, 50, 10, 2, 60, 0, 0, 0, 2, 5};
    tbl[1] = '{"tie_lowest", 3, 7, 7, 7, 3, 0, 0, 9, 0, 1, 3};
    tbl[2] = '{"gate_one_vote", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{"saturate", 16, 0, 0, 1, 0, 0, 0, 0, 0, 3, 15};
    tbl[4] = '{"bias_class1", 3, 10, 0, 0, 0, 0, 0, 0, 2, 2, 3};
    tbl[5] = '{"bias_wrap", 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    tbl[6] = '{"negative", 3, -5, -3, -100, 1, -1, -1, 0, 0, 2, 3};
    w4[0]  = '{"win_c1", 3, 0, 9, 0, 0, 0, 0, 0, 0, 2, 3};
    w4[1]  = '{"win_c2_a", 3, 0, 0, 9, 0, 0, 0, 0, 0, 3, 3};
    w4[2]  = '{"win_c2_b", 3, 0, 0, 9, 0, 0, 0, 0, 0, 3, 3};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) apply_window(tbl[i]);
    drain();

    // Freeze at timer=8 with inputs toggling; bias still steps through a full wrap
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.valid_in = (c < 3); set_vec(0, 0, 5);
      @(negedge clk);
    end
    for (int f = 0; f < 40; f++) begin
      if (f >= 11 && f < 19 && (f % 2) == 1) chk("freeze bias_sel", int'(bus.bias_sel), bsel_exp);
      bus.en = 1'b0;
      bus.valid_in = ((f % 2) == 1);
      set_vec(9, 0, 0);
      bus.bias_next = (f >= 10 && f < 18 && (f % 2) == 0);
      if (bus.bias_next) bsel_exp = (bsel_exp == int'(NC)) ? 0 : bsel_exp + 1;
      @(negedge clk);
    end
    for (int r = 0; r < 8; r++) begin
      if (r == 0) push_exp(3, 3, cyc + 8);
      idle();
      @(negedge clk);
    end

    // Mid-window reset at timer=10 discards the five class-0 votes already counted
    for (int c = 0; c < 10; c++) begin
      if (c == 1) chk("pre-reset bias_sel", int'(bus.bias_sel), bsel_exp);
      bus.bias_next = (c == 0);
      if (c == 0) bsel_exp = (bsel_exp == int'(NC)) ? 0 : bsel_exp + 1;
      bus.valid_in = (c >= 2 && c < 7); set_vec(40, 0, 0);
      @(negedge clk);
    end
    do_reset();
    for (int c = 0; c < int'(VP); c++) begin
      if (c == 0) push_exp(0, 0, cyc + int'(VP));
      bus.valid_in = (c == 3); set_vec(0, 0, 4);
      @(negedge clk);
    end
    drain();

    // A vote in the close cycle belongs to the closing window, not the next one
    do_reset();
    for (int c = 0; c < int'(VP); c++) begin
      if (c == 0) push_exp(3, 2, cyc + int'(VP));
      bus.valid_in = (c == 0 || c == int'(VP) - 1); set_vec(0, 0, 3);
      @(negedge clk);
    end
    apply_window('{"after_close", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    drain();

    // Winners class 1, 2, 2 across three windows
    do_reset();
    for (int i = 0; i < 3; i++) apply_window(w4[i]);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
